seven_seg_scan: RTL

Parametrised N-digit multiplexed seven-segment driver: one-clock scan engine with built-in prescaler, hex decode, leading-zero blanking, per-digit decimal point and blink, PWM brightness, and double-buffered frame-synchronous loading. It replaces the fixed 4-digit clock-divider/display pair at the top level. It drives the digit enables and segment lines directly from the system clock.

---
 rtl/seven_seg_scan.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed N-digit seven-segment driver with prescaler, hex decode, blanking, blink and PWM
// Ports: clk/rst (sync, active-high); value/dp_in/blink_in captured by load into staging,
// promoted to display at each frame boundary; blank_lz and brightness are live.
// Outputs pending, frame_start, digit_en, segs {a..g}, dp are registered one cycle behind scan state.
module seven_seg_scan #(
    parameter int DIGITS        = 4,
    parameter int SCAN_DIV      = 12500,
    parameter int BRIGHT_W      = 3,
    parameter int BLINK_DIV     = 32,
    parameter bit EN_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  load,
    output logic                  pending,
    output logic                  frame_start,
    output logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            segs,
    output logic                  dp
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam int PW = CW + BRIGHT_W + 1;
    localparam logic [111:0] SEG_LUT = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [FW-1:0]       fc_q, fc_d;
    logic                phase_q, phase_d;
    logic [4*DIGITS-1:0] stg_val_q, stg_val_d, disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]   stg_blk_q, stg_blk_d, disp_blk_q, disp_blk_d;
    logic                pend_q, pend_d;
    logic                bnd_q, bnd_d;
    logic                pending_q, pending_d;
    logic                frame_start_q, frame_start_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic [6:0]          segs_q, segs_d;
    logic                dp_q, dp_d;

    logic                tick, bnd, z, on, blink_blank;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   lz_blank, en;
    logic [PW-1:0]       lhs, rhs;

    always_comb begin
        tick = cnt_q == CW'(SCAN_DIV - 1);
        bnd = tick && idx_q == IW'(DIGITS - 1);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = !tick ? idx_q : bnd ? '0 : idx_q + 1'b1;
        fc_d = !bnd ? fc_q : (fc_q == FW'(BLINK_DIV - 1)) ? '0 : fc_q + 1'b1;
        phase_d = phase_q ^ (bnd && fc_q == FW'(BLINK_DIV - 1));
        stg_val_d = load ? value : stg_val_q;
        stg_dp_d = load ? dp_in : stg_dp_q;
        stg_blk_d = load ? blink_in : stg_blk_q;
        // a load landing on the boundary bypasses staging and is never pending
        pend_d = load ? !bnd : (bnd ? 1'b0 : pend_q);
        disp_val_d = (load && bnd) ? value : (bnd && pend_q) ? stg_val_q : disp_val_q;
        disp_dp_d = (load && bnd) ? dp_in : (bnd && pend_q) ? stg_dp_q : disp_dp_q;
        disp_blk_d = (load && bnd) ? blink_in : (bnd && pend_q) ? stg_blk_q : disp_blk_q;
        // walk down from the top digit; z stays high while every nibble seen so far is zero
        lz_blank = '0;
        z = blank_lz;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            z = z && disp_val_q[d*4 +: 4] == 4'h0;
            lz_blank[d] = z;
        end
        nib = disp_val_q[{idx_q, 2'b00} +: 4];
        blink_blank = phase_q && disp_blk_q[idx_q];
        lhs = PW'(cnt_q) << BRIGHT_W;
        rhs = (PW'(brightness) + PW'(1)) * PW'(SCAN_DIV);
        on = lhs < rhs;
        en = on ? (DIGITS'(1) << idx_q) : '0;
        digit_en_d = EN_ACTIVE_LOW ? ~en : en;
        segs_d = (blink_blank || lz_blank[idx_q]) ? 7'h00 : SEG_LUT[nib*7 +: 7];
        dp_d = !blink_blank && disp_dp_q[idx_q];
        bnd_d = bnd;
        // delayed twice so the pulse lines up with digit 0's registered outputs
        frame_start_d = bnd_q;
        pending_d = pend_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            fc_q <= '0;
            phase_q <= 1'b0;
            stg_val_q <= '0;
            stg_dp_q <= '0;
            stg_blk_q <= '0;
            disp_val_q <= '0;
            disp_dp_q <= '0;
            disp_blk_q <= '0;
            pend_q <= 1'b0;
            bnd_q <= 1'b0;
            pending_q <= 1'b0;
            frame_start_q <= 1'b0;
            digit_en_q <= {DIGITS{EN_ACTIVE_LOW}};
            segs_q <= '0;
            dp_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            fc_q <= fc_d;
            phase_q <= phase_d;
            stg_val_q <= stg_val_d;
            stg_dp_q <= stg_dp_d;
            stg_blk_q <= stg_blk_d;
            disp_val_q <= disp_val_d;
            disp_dp_q <= disp_dp_d;
            disp_blk_q <= disp_blk_d;
            pend_q <= pend_d;
            bnd_q <= bnd_d;
            pending_q <= pending_d;
            frame_start_q <= frame_start_d;
            digit_en_q <= digit_en_d;
            segs_q <= segs_d;
            dp_q <= dp_d;
        end
    end

    assign pending = pending_q;
    assign frame_start = frame_start_q;
    assign digit_en = digit_en_q;
    assign segs = segs_q;
    assign dp = dp_q;
endmodule
